// File: rtl/riscv_pkg.sv
// Shared definitions for the multi-cycle RV32I core: sequencer states,
// datapath width and the default PC vectors.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [XLEN-1:0] TRAP_VECTOR_DEF  = 32'h0000_0100;
  localparam logic [XLEN-1:0] PC_STEP          = 32'd4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    WAIT   = 3'd2,
    EXEC   = 3'd3,
    HALTED = 3'd4
  } seq_state_t;
endpackage

// File: rtl/next_pc_select.sv
// Next-PC priority mux (trap > jump > branch > sequential) with detection of
// misaligned redirect targets, which are folded into the trap path.
import riscv_pkg::*;

module next_pc_select #(
  parameter logic [XLEN-1:0] TRAP_VECTOR = TRAP_VECTOR_DEF
) (
  input  logic [XLEN-1:0] pc,
  input  logic            trap,
  input  logic            jump,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] jump_target,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] next_pc,
  output logic            redirect_trap
);
  logic [XLEN-1:0] target;
  logic            redirect;

  always_comb begin
    redirect = 1'b0;
    target   = pc + PC_STEP;
    if (jump) begin
      redirect = 1'b1;
      target   = jump_target;
    end else if (branch_taken) begin
      redirect = 1'b1;
      target   = branch_target;
    end
  end

  // Only the target actually selected is checked for alignment.
  always_comb begin
    redirect_trap = trap || (redirect && (target[1:0] != 2'b00));
    next_pc       = redirect_trap ? TRAP_VECTOR : target;
  end
endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer for the non-pipelined RV32I core: owns the PC,
// runs the imem req/gnt/rvalid handshake and retires on ex_done.
import riscv_pkg::*;

module pc_sequencer #(
  parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = TRAP_VECTOR_DEF
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr,
  output logic            instr_valid,
  input  logic            ex_done,
  input  logic            trap,
  input  logic            jump,
  input  logic            branch_taken,
  input  logic            halt,
  input  logic [XLEN-1:0] jump_target,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] pc_out,
  output logic            trap_taken,
  output logic            halted,
  output logic [XLEN-1:0] instret
);
  seq_state_t      state;
  logic [XLEN-1:0] next_pc;
  logic            redirect_trap;

  next_pc_select #(.TRAP_VECTOR(TRAP_VECTOR)) u_next_pc (
    .pc            (pc_out),
    .trap          (trap),
    .jump          (jump),
    .branch_taken  (branch_taken),
    .jump_target   (jump_target),
    .branch_target (branch_target),
    .next_pc       (next_pc),
    .redirect_trap (redirect_trap)
  );

  // Pure state decode so the request never glitches off the registered state.
  assign imem_req  = (state == FETCH);
  assign imem_addr = pc_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc_out      <= RESET_VECTOR;
      instr       <= '0;
      instr_valid <= 1'b0;
      trap_taken  <= 1'b0;
      halted      <= 1'b0;
      instret     <= '0;
    end else begin
      instr_valid <= 1'b0;
      trap_taken  <= 1'b0;
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (imem_gnt) begin
            if (imem_rvalid) begin
              instr       <= imem_rdata;
              instr_valid <= 1'b1;
              state       <= EXEC;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            state       <= EXEC;
          end
        end
        EXEC: begin
          if (ex_done) begin
            pc_out     <= next_pc;
            trap_taken <= redirect_trap;
            if (!redirect_trap) instret <= instret + 1'b1;
            if (halt && !redirect_trap) begin
              halted <= 1'b1;
              state  <= HALTED;
            end else begin
              state <= FETCH;
            end
          end
        end
        HALTED: state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
